// File: rtl/aes_kat_pkg.sv
// Shared types and FIPS-197 known-answer constants for the AES self-test controller.
package aes_kat_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StKeyInit,
        StKeyWait,
        StEncStart,
        StEncWait,
        StDecStart,
        StDecWait,
        StNextVec,
        StDone
    } kat_state_e;

    localparam logic KEYLEN_128 = 1'b0;
    localparam logic KEYLEN_256 = 1'b1;

    localparam int unsigned ROM_IDX_W = 4;

    typedef struct packed {
        logic         keylen;
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } kat_vec_t;

    // 128-bit keys sit left-aligned in the 256-bit key field.
    localparam kat_vec_t KAT_AES128 = '{
        keylen: KEYLEN_128,
        key:    {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
        pt:     128'h00112233445566778899aabbccddeeff,
        ct:     128'h69c4e0d86a7b0430d8cdb78070b4c55a
    };

    localparam kat_vec_t KAT_AES256 = '{
        keylen: KEYLEN_256,
        key:    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
        pt:     128'h00112233445566778899aabbccddeeff,
        ct:     128'h8ea2b7ca516745bfeafc49904b496089
    };

    function automatic logic is_wait_state(kat_state_e s);
        return (s == StKeyWait) || (s == StEncWait) || (s == StDecWait);
    endfunction

endpackage

// File: rtl/aes_kat_rom.sv
// Known-answer vector ROM: even indices hold the AES-128 vector, odd indices the AES-256 one.
module aes_kat_rom
    import aes_kat_pkg::*;
(
    input  logic [ROM_IDX_W-1:0] i_idx,
    output kat_vec_t             o_vec
);

    always_comb begin
        case (i_idx)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15: o_vec = KAT_AES256;
            default:                                           o_vec = KAT_AES128;
        endcase
    end

endmodule

// File: rtl/aes_kat_bist.sv
// AES known-answer self-test: sequences key expansion, encrypt and optional decrypt per
// ROM vector, checks each result and reports pass, fail count, first failure and timeout.
module aes_kat_bist
    import aes_kat_pkg::*;
#(
    parameter int unsigned  NUM_VECTORS    = 4,
    parameter int unsigned  TIMEOUT_CYCLES = 1024,
    parameter bit           CHECK_DECRYPT  = 1'b1,
    localparam int unsigned FC_W           = $clog2(2 * NUM_VECTORS + 1),
    localparam int unsigned IDX_W          = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [FC_W-1:0]  fail_count,
    output logic [IDX_W-1:0] first_fail_idx,
    output logic             aes_init,
    output logic             aes_next,
    output logic             aes_encdec,
    output logic             aes_keylen,
    output logic [255:0]     aes_key,
    output logic [127:0]     aes_block,
    input  logic             aes_ready,
    input  logic             aes_result_valid,
    input  logic [127:0]     aes_result
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    kat_state_e           r_state, w_state_d;
    logic [CNT_W-1:0]     r_wait_cnt;
    logic [IDX_W-1:0]     r_idx, w_idx_d;
    logic [FC_W-1:0]      r_fail_cnt;
    logic [IDX_W-1:0]     r_first_fail;
    logic                 r_timeout;
    logic                 r_keylen;
    logic [255:0]         r_key;
    logic [127:0]         r_block;
    logic                 r_encdec;

    kat_vec_t             w_vec;
    logic [ROM_IDX_W-1:0] w_rom_idx;
    logic                 w_accept, w_in_wait, w_guard, w_complete, w_expired;
    logic                 w_last_vec, w_mismatch;
    logic [127:0]         w_expected;

    // ROM is addressed with the upcoming index so the key is ready in the KEY_INIT cycle.
    aes_kat_rom u_rom (
        .i_idx (w_rom_idx),
        .o_vec (w_vec)
    );

    always_comb begin
        w_accept   = start && ((r_state == StIdle) || (r_state == StDone));
        w_in_wait  = is_wait_state(r_state);
        w_guard    = (r_wait_cnt == '0);
        w_complete = w_in_wait && !w_guard && aes_ready
                     && ((r_state == StKeyWait) || aes_result_valid);
        w_expired  = w_in_wait && !w_complete
                     && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        w_last_vec = (r_idx == IDX_W'(NUM_VECTORS - 1));
        w_expected = (r_state == StDecWait) ? w_vec.pt : w_vec.ct;
        w_mismatch = w_complete && ((r_state == StEncWait) || (r_state == StDecWait))
                     && (aes_result != w_expected);

        if (w_accept) begin
            w_idx_d = '0;
        end else if ((r_state == StNextVec) && !w_last_vec) begin
            w_idx_d = r_idx + IDX_W'(1);
        end else begin
            w_idx_d = r_idx;
        end
        w_rom_idx = ROM_IDX_W'(w_idx_d);
    end

    always_comb begin
        w_state_d = r_state;
        busy      = 1'b1;
        done      = 1'b0;
        aes_init  = 1'b0;
        aes_next  = 1'b0;
        unique case (r_state)
            StIdle: begin
                busy = 1'b0;
                if (w_accept) w_state_d = StKeyInit;
            end
            StKeyInit: begin
                aes_init  = 1'b1;
                w_state_d = StKeyWait;
            end
            StKeyWait: begin
                if (w_complete)     w_state_d = StEncStart;
                else if (w_expired) w_state_d = StDone;
            end
            StEncStart: begin
                aes_next  = 1'b1;
                w_state_d = StEncWait;
            end
            StEncWait: begin
                if (w_complete)     w_state_d = CHECK_DECRYPT ? StDecStart : StNextVec;
                else if (w_expired) w_state_d = StDone;
            end
            StDecStart: begin
                aes_next  = 1'b1;
                w_state_d = StDecWait;
            end
            StDecWait: begin
                if (w_complete)     w_state_d = StNextVec;
                else if (w_expired) w_state_d = StDone;
            end
            StNextVec: begin
                w_state_d = w_last_vec ? StDone : StKeyInit;
            end
            StDone: begin
                busy = 1'b0;
                done = 1'b1;
                if (w_accept) w_state_d = StKeyInit;
            end
            default: w_state_d = StIdle;
        endcase
        pass = done && (r_fail_cnt == '0) && !r_timeout;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_wait_cnt   <= '0;
            r_idx        <= '0;
            r_fail_cnt   <= '0;
            r_first_fail <= '0;
            r_timeout    <= 1'b0;
            r_keylen     <= 1'b0;
            r_key        <= '0;
            r_block      <= '0;
            r_encdec     <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            // The count restarts on every wait-state entry; value 0 marks the guard cycle.
            r_wait_cnt <= (is_wait_state(w_state_d) && (w_state_d == r_state))
                          ? r_wait_cnt + CNT_W'(1) : '0;

            if (w_accept) begin
                r_fail_cnt   <= '0;
                r_first_fail <= '0;
                r_timeout    <= 1'b0;
            end else begin
                if (w_mismatch) begin
                    if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + FC_W'(1);
                    if (r_fail_cnt == '0) r_first_fail <= r_idx;
                end
                if (w_expired) r_timeout <= 1'b1;
            end

            if (w_state_d == StKeyInit) begin
                r_key    <= w_vec.key;
                r_keylen <= w_vec.keylen;
            end
            if (w_state_d == StEncStart) begin
                r_block  <= w_vec.pt;
                r_encdec <= 1'b1;
            end
            if (w_state_d == StDecStart) begin
                r_block  <= w_vec.ct;
                r_encdec <= 1'b0;
            end
        end
    end

    assign timeout        = r_timeout;
    assign fail_count     = r_fail_cnt;
    assign first_fail_idx = r_first_fail;
    assign aes_encdec     = r_encdec;
    assign aes_keylen     = r_keylen;
    assign aes_key        = r_key;
    assign aes_block      = r_block;

endmodule
